// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e : FSM state encoding (IDLE, HDR, DATA)
//   HDR_BASE    : base value of the source-ID header byte
//   hdr_byte()  : header byte for a given port index
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [7:0] HDR_BASE = 8'h80;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    return HDR_BASE + {5'b00000, idx};
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   valid : per-port request bits
//   ptr   : port with highest priority this round
//   idx   : first valid port at or after ptr, wrapping modulo NUM_REQ
//   any   : at least one port is valid
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [2:0]         ptr,
  output logic [2:0]         idx,
  output logic               any
);

  always_comb begin
    int cand;
    cand = 0;
    idx  = 3'd0;
    any  = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      // Inner loop keeps every bit select constant.
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any && (j == cand) && valid[j]) begin
          any = 1'b1;
          idx = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of a UART transmit buffer.
// A port keeps the grant for a whole packet (or until MAX_PKT_LEN bytes),
// optionally preceded by a source-ID header byte.
//   req_valid/req_data/req_last/req_ready : per-port byte streams
//   tx_data_out/write_tx_data             : byte and write strobe to the UART
//   tx_buffer_full                        : UART FIFO full, blocks all writes
//   grant/busy/pkt_trunc                  : registered status
//
// state | meaning
// IDLE  | arbitrate among valid ports, one cycle between packets
// HDR   | write the header byte of the granted port
// DATA  | forward bytes of the granted port until last or length limit
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HEADER_EN   = 1,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data_out,
  output logic                 write_tx_data,
  input  logic                 tx_buffer_full,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 pkt_trunc
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PKT_LEN);
  localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               trunc_q, trunc_d;

  logic [2:0] pick_idx;
  logic       pick_any;

  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Owner's request lines; loop form avoids variable bit selects.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx_q == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rr_ptr_d      = rr_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    grant_d       = grant_q;
    trunc_d       = 1'b0;
    req_ready     = '0;
    write_tx_data = 1'b0;
    tx_data_out   = 8'h00;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          idx_d = pick_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            grant_d[i] = (pick_idx == 3'(i));
          end
          state_d = (HEADER_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        if (!tx_buffer_full) begin
          write_tx_data = 1'b1;
          tx_data_out   = hdr_byte(idx_q);
          state_d       = DATA;
        end
      end
      DATA: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (idx_q == 3'(i)) req_ready[i] = !tx_buffer_full;
        end
        if (sel_valid && !tx_buffer_full) begin
          write_tx_data = 1'b1;
          tx_data_out   = sel_data;
          byte_cnt_d    = byte_cnt_q + 8'd1;
          // byte_cnt never exceeds MAX_LEN-1, so the +1 cannot wrap.
          if (sel_last || (byte_cnt_q + 8'd1 == MAX_LEN)) begin
            state_d    = IDLE;
            grant_d    = '0;
            byte_cnt_d = 8'd0;
            rr_ptr_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
            trunc_d    = !sel_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      rr_ptr_q   <= 3'd0;
      byte_cnt_q <= 8'd0;
      grant_q    <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      grant_q    <= grant_d;
      trunc_q    <= trunc_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign pkt_trunc = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, HEADER_EN=1, MAX_PKT_LEN=4).
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data_out;
  logic           write_tx_data;
  logic           tx_buffer_full = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;
  logic           pkt_trunc;

  uart_tx_arbiter #(.NUM_REQ(N), .HEADER_EN(1), .MAX_PKT_LEN(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .tx_data_out    (tx_data_out),
    .write_tx_data  (write_tx_data),
    .tx_buffer_full (tx_buffer_full),
    .grant          (grant),
    .busy           (busy),
    .pkt_trunc      (pkt_trunc)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [7:0]   exp_q[$];
  logic [8:0]   drv_q[N][$];
  logic [N-1:0] stall = '0;
  logic         full_sched = 1'b0;
  int           cyc = 0;
  int           wr_cyc[$];
  logic [N-1:0] wr_grant[$];
  int           trunc_cnt = 0;
  int           trunc_cyc = -1;
  int           wr_when_full = 0;
  int           bad_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(negedge clk);
    #3;
  endtask

  task automatic enq(input int p, input logic [7:0] b, input logic last);
    drv_q[p].push_back({last, b});
  endtask

  task automatic expb(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic clear_logs();
    wr_cyc.delete();
    wr_grant.delete();
  endtask

  task automatic wait_writes(input int n, input string name);
    int k;
    k = 0;
    while (wr_cyc.size() < n && k < 300) begin
      sync();
      k++;
    end
    if (wr_cyc.size() < n) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d writes expected %0d", name, wr_cyc.size(), n);
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      sync();
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic flush_all();
    for (int p = 0; p < N; p++) drv_q[p].delete();
    exp_q.delete();
    stall = '0;
    full_sched = 1'b0;
  endtask

  task automatic do_reset();
    sync();
    reset_n = 1'b0;
    flush_all();
    repeat (2) sync();
    reset_n = 1'b1;
    sync();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_write"}, {31'd0, write_tx_data}, 32'd0);
    chk({name, "_ready"}, {28'd0, req_ready}, 32'd0);
    chk({name, "_data"},  {24'd0, tx_data_out}, 32'd0);
    chk({name, "_grant"}, {28'd0, grant}, 32'd0);
    chk({name, "_busy"},  {31'd0, busy}, 32'd0);
    chk({name, "_trunc"}, {31'd0, pkt_trunc}, 32'd0);
  endtask

  // Drivers: present queue heads on the falling edge, retire on accept.
  initial begin
    forever begin
      @(negedge clk);
      tx_buffer_full = full_sched;
      for (int p = 0; p < N; p++) begin
        if (drv_q[p].size() > 0 && !stall[p]) begin
          req_valid[p]         = 1'b1;
          req_data[8*p +: 8]   = drv_q[p][0][7:0];
          req_last[p]          = drv_q[p][0][8];
        end else begin
          req_valid[p]         = 1'b0;
          req_data[8*p +: 8]   = 8'h00;
          req_last[p]          = 1'b0;
        end
      end
      #1;
      for (int p = 0; p < N; p++) begin
        if (req_valid[p] && req_ready[p]) void'(drv_q[p].pop_front());
      end
    end
  end

  // Monitor: compares every UART write against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (reset_n && write_tx_data) begin
        if (tx_buffer_full) wr_when_full++;
        wr_cyc.push_back(cyc);
        wr_grant.push_back(grant);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got %0h expected no write", tx_data_out);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {24'd0, tx_data_out}, {24'd0, e});
        end
      end
      if (reset_n && pkt_trunc) begin
        trunc_cnt++;
        trunc_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) sync();
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    sync();

    // Single packet with header from port 2.
    clear_logs();
    expb(8'h82); expb(8'h41); expb(8'h42); expb(8'h43);
    enq(2, 8'h41, 1'b0); enq(2, 8'h42, 1'b0); enq(2, 8'h43, 1'b1);
    wait_drain("t1");
    chk("t1_nwrites", wr_cyc.size(), 4);
    if (wr_cyc.size() >= 4) begin
      chk("t1_consecutive", wr_cyc[3] - wr_cyc[0], 3);
      for (int i = 0; i < 4; i++) chk("t1_grant", {28'd0, wr_grant[i]}, 32'h4);
    end
    sync();
    chk("t1_grant_after", {28'd0, grant}, 32'd0);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // Contention from reset: ports 0 and 3, port 0 has a second packet.
    do_reset();
    clear_logs();
    expb(8'h80); expb(8'ha0); expb(8'ha1);
    expb(8'h83); expb(8'hd0); expb(8'hd1);
    expb(8'h80); expb(8'ha2); expb(8'ha3);
    enq(0, 8'ha0, 1'b0); enq(0, 8'ha1, 1'b1); enq(0, 8'ha2, 1'b0); enq(0, 8'ha3, 1'b1);
    enq(3, 8'hd0, 1'b0); enq(3, 8'hd1, 1'b1);
    wait_drain("t2");
    chk("t2_nwrites", wr_cyc.size(), 9);
    if (wr_cyc.size() >= 9) begin
      chk("t2_idle_gap", wr_cyc[3] - wr_cyc[2], 2);
      chk("t2_grant_p3", {28'd0, wr_grant[3]}, 32'h8);
      chk("t2_grant_p0_again", {28'd0, wr_grant[6]}, 32'h1);
    end

    // Backpressure for 5 cycles mid-packet; 4 bytes with last on the limit.
    clear_logs();
    expb(8'h81); expb(8'h11); expb(8'h12); expb(8'h13); expb(8'h14);
    enq(1, 8'h11, 1'b0); enq(1, 8'h12, 1'b0); enq(1, 8'h13, 1'b0); enq(1, 8'h14, 1'b1);
    wait_writes(2, "t3");
    full_sched = 1'b1;
    repeat (5) sync();
    full_sched = 1'b0;
    wait_drain("t3");
    sync();
    chk("t3_nwrites", wr_cyc.size(), 5);
    if (wr_cyc.size() >= 5) chk("t3_stall_gap", wr_cyc[2] - wr_cyc[1], 6);
    chk("t3_no_trunc", trunc_cnt, 0);

    // Truncation at 4 bytes, remainder as a new packet.
    clear_logs();
    expb(8'h81); expb(8'hb1); expb(8'hb2); expb(8'hb3); expb(8'hb4);
    expb(8'h81); expb(8'hb5); expb(8'hb6);
    for (int i = 1; i <= 6; i++) enq(1, 8'hb0 + 8'(i), (i == 6));
    wait_drain("t4");
    sync();
    chk("t4_nwrites", wr_cyc.size(), 8);
    chk("t4_trunc_count", trunc_cnt, 1);
    if (wr_cyc.size() >= 8) begin
      chk("t4_trunc_cycle", trunc_cyc, wr_cyc[4] + 1);
      chk("t4_rehdr_gap", wr_cyc[5] - wr_cyc[4], 2);
    end

    // Owner stall: port 0 drops valid for 10 cycles while port 1 waits.
    clear_logs();
    expb(8'h80); expb(8'hc0); expb(8'hc1); expb(8'hc2);
    expb(8'h81); expb(8'he0);
    enq(0, 8'hc0, 1'b0); enq(0, 8'hc1, 1'b0); enq(0, 8'hc2, 1'b1);
    enq(1, 8'he0, 1'b1);
    wait_writes(2, "t5");
    stall[0] = 1'b1;
    bad_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      sync();
      if (grant !== 4'b0001 || req_ready[1] !== 1'b0 || write_tx_data !== 1'b0 || busy !== 1'b1)
        bad_cycles++;
    end
    chk("t5_stall_bad_cycles", bad_cycles, 0);
    stall[0] = 1'b0;
    wait_drain("t5");
    chk("t5_nwrites", wr_cyc.size(), 6);
    if (wr_cyc.size() >= 6) chk("t5_grant_p1", {28'd0, wr_grant[4]}, 32'h2);

    // Asynchronous reset mid-DATA, then arbitration restarts at port 0.
    clear_logs();
    expb(8'h82); expb(8'hf0);
    enq(2, 8'hf0, 1'b0); enq(2, 8'hf1, 1'b0); enq(2, 8'hf2, 1'b0); enq(2, 8'hf3, 1'b1);
    wait_writes(2, "t6");
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("t6_async");
    flush_all();
    repeat (2) sync();
    reset_n = 1'b1;
    sync();
    clear_logs();
    expb(8'h81); expb(8'h61); expb(8'h83); expb(8'h71);
    enq(3, 8'h71, 1'b1);
    enq(1, 8'h61, 1'b1);
    wait_drain("t6");
    chk("t6_nwrites", wr_cyc.size(), 4);
    if (wr_cyc.size() >= 4) chk("t6_first_grant", {28'd0, wr_grant[0]}, 32'h2);

    sync();
    chk("no_write_while_full", wr_when_full, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
